// File: rtl/iic_slave_regs.sv
// I2C target serving an NREG x 8-bit register file (write: addr, ptr, data...; read: data... from ptr).
// Define IIC_SLAVE_AUTOINC_EN to advance the pointer after every data byte.
`timescale 1ns/1ps
module iic_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h38,
    parameter int         NREG     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              scl,
    inout  wire               sda,
    output logic [8*NREG-1:0] regs,
    output logic              wr_strobe,
    output logic [7:0]        wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
`ifdef IIC_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK_CHK, WAIT_STOP
    } state_t;

    // [0] first sync FF, [1] synchronized value, [2] previous synchronized value
    logic [2:0] scl_pipe_reg, sda_pipe_reg;
    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] ptr_reg, ptr_next;
    logic       oe_reg, oe_next;
    logic       busy_reg, busy_next;
    logic       wr_strobe_reg;
    logic [7:0] wr_addr_reg, wr_data_reg;
    logic [7:0] regs_mem [0:NREG-1];
    logic       store;

    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] shift_in, nxt_ptr, cur_byte, reload_byte;

    assign scl_s     = scl_pipe_reg[1];
    assign sda_s     = sda_pipe_reg[1];
    assign scl_rise  = scl_s & ~scl_pipe_reg[2];
    assign scl_fall  = ~scl_s & scl_pipe_reg[2];
    assign start_det = scl_s & scl_pipe_reg[2] & sda_pipe_reg[2] & ~sda_s;
    assign stop_det  = scl_s & scl_pipe_reg[2] & ~sda_pipe_reg[2] & sda_s;
    assign shift_in  = {shift_reg[6:0], sda_s};
    assign nxt_ptr   = AUTOINC ? (ptr_reg + 8'd1) : ptr_reg;

    // Out-of-range pointers read back as all ones
    always_comb begin
        cur_byte    = 8'hFF;
        reload_byte = 8'hFF;
        if ({1'b0, ptr_reg} < 9'(NREG))
            cur_byte = regs_mem[ptr_reg[IW-1:0]];
        if ({1'b0, nxt_ptr} < 9'(NREG))
            reload_byte = regs_mem[nxt_ptr[IW-1:0]];
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        ptr_next   = ptr_reg;
        oe_next    = oe_reg;
        busy_next  = busy_reg;
        store      = 1'b0;
        if (!en || stop_det) begin
            state_next = IDLE;
            oe_next    = 1'b0;
            busy_next  = 1'b0;
        end else if (start_det) begin
            state_next = ADDR;
            cnt_next   = 4'd0;
            oe_next    = 1'b0;
        end else begin
            case (state_reg)
                ADDR, PTR, WDATA: if (scl_rise) begin
                    shift_next = shift_in;
                    cnt_next   = cnt_reg + 4'd1;
                    if (cnt_reg == 4'd7) begin
                        cnt_next = 4'd0;
                        if (state_reg == ADDR) begin
                            if (shift_in[7:1] == DEV_ADDR) begin
                                state_next = ADDR_ACK;
                                busy_next  = 1'b1;
                            end else begin
                                state_next = WAIT_STOP;
                                busy_next  = 1'b0;
                            end
                        end else if (state_reg == PTR) begin
                            ptr_next   = shift_in;
                            state_next = PTR_ACK;
                        end else begin
                            store      = ({1'b0, ptr_reg} < 9'(NREG));
                            ptr_next   = nxt_ptr;
                            state_next = WDATA_ACK;
                        end
                    end
                end
                // First falling edge starts the ACK pulse, the second ends it
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                    if (!oe_reg) begin
                        oe_next = 1'b1;
                    end else begin
                        oe_next  = 1'b0;
                        cnt_next = 4'd0;
                        if (state_reg != ADDR_ACK) begin
                            state_next = WDATA;
                        end else if (shift_reg[0]) begin
                            state_next = RDATA;
                            shift_next = cur_byte;
                            oe_next    = ~cur_byte[7];
                        end else begin
                            state_next = PTR;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_next = cnt_reg + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_reg == 4'd8) begin
                            oe_next    = 1'b0;
                            cnt_next   = 4'd0;
                            state_next = RACK_CHK;
                        end else begin
                            oe_next = ~shift_reg[3'd7 - cnt_reg[2:0]];
                        end
                    end
                end
                RACK_CHK: if (scl_rise) begin
                    if (!sda_s) begin
                        ptr_next   = nxt_ptr;
                        shift_next = reload_byte;
                        cnt_next   = 4'd0;
                        state_next = RDATA;
                    end else begin
                        busy_next  = 1'b0;
                        state_next = WAIT_STOP;
                    end
                end
                WAIT_STOP: oe_next = 1'b0;
                default:   state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_pipe_reg  <= 3'b111;
            sda_pipe_reg  <= 3'b111;
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            shift_reg     <= 8'h00;
            ptr_reg       <= 8'h00;
            oe_reg        <= 1'b0;
            busy_reg      <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= 8'h00;
            wr_data_reg   <= 8'h00;
            for (int i = 0; i < NREG; i++)
                regs_mem[i] <= 8'h00;
        end else begin
            scl_pipe_reg  <= {scl_pipe_reg[1:0], scl};
            sda_pipe_reg  <= {sda_pipe_reg[1:0], sda};
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            ptr_reg       <= ptr_next;
            oe_reg        <= oe_next;
            busy_reg      <= busy_next;
            wr_strobe_reg <= store;
            if (store) begin
                regs_mem[ptr_reg[IW-1:0]] <= shift_in;
                wr_addr_reg               <= ptr_reg;
                wr_data_reg               <= shift_in;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_flat
            assign regs[8*gi +: 8] = regs_mem[gi];
        end
    endgenerate

    assign sda       = oe_reg ? 1'b0 : 1'bz;
    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign busy      = busy_reg;

endmodule
